// File: rtl/serial_sub_pkg.sv
// Purpose: shared types and constants for the bit-serial subtraction controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_sub_pkg;

    localparam int DEF_WIDTH = 8;

    // 2'b11 is unused; the controller treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_sub.sv
// Purpose: 1-bit full subtractor cell, computes a - b - bin.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic barrow
);

    assign diff   = a ^ b ^ bin;
    // Borrow when b exceeds a, or when a equals b and a borrow is pending.
    assign barrow = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Purpose: sequences one full_sub cell over WIDTH bits, LSB first (SERIAL_SUB_BIN_EN adds bin_init).
// Latency: WIDTH+1 cycles from accepted start to the one-cycle done strobe.
// Backpressure: start is honoured only in IDLE; starts in RUN/DONE are dropped, not queued.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
    input  logic             bin_init,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             bor;
    logic             bin_val;
    logic             cell_diff;
    logic             cell_bor;

`ifdef SERIAL_SUB_BIN_EN
    assign bin_val = bin_init;
`else
    assign bin_val = 1'b0;
`endif

    full_sub u_cell (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .bin    (bor),
        .diff   (cell_diff),
        .barrow (cell_bor)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: RUN lasts exactly WIDTH cycles, DONE exactly one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-bit shifting and result latching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            bor        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        bor  <= bin_val;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {cell_diff, res_sr[WIDTH-1:1]};
                    bor    <= cell_bor;
                    if (cnt == LAST) begin
                        // Last bit: publish result; counter holds rather than wrapping.
                        diff       <= {cell_diff, res_sr[WIDTH-1:1]};
                        borrow_out <= cell_bor;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Purpose: directed self-checking bench for serial_sub_ctrl at WIDTH=8 (SERIAL_SUB_BIN_EN optional).
// Latency: checks done at WIDTH+1 cycles after the start sample.
// Backpressure: checks that starts in RUN/DONE are dropped.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin_init;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int total = 0;
    int bad   = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
`ifdef SERIAL_SUB_BIN_EN
        .bin_init   (bin_init),
`endif
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bounded wait for IDLE, sampled on the falling edge.
    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (busy === 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_timeout: busy=%b required 0", nm, busy);
        end
    endtask

    // One isolated operation: latency, done width, busy length and held result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                          input logic [W-1:0] ed, input logic eb, input string nm);
        int lat;
        int ndone;
        int nbusy;
        logic [W-1:0] d_at;
        logic         b_at;
        wait_idle(nm);
        a = ta; b = tb_; bin_init = tbin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ta; b = ~tb_; bin_init = ~tbin;
        lat = 0; ndone = 0; nbusy = 0; d_at = '0; b_at = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin
                ndone++;
                if (lat == 0) begin
                    lat  = k;
                    d_at = diff;
                    b_at = borrow_out;
                end
            end
        end
        total++; if (lat !== 9)  begin bad++; $display("FAIL %s_latency: got %0d required 9", nm, lat); end
        total++; if (ndone !== 1) begin bad++; $display("FAIL %s_done_count: got %0d required 1", nm, ndone); end
        total++; if (nbusy !== 9) begin bad++; $display("FAIL %s_busy_cycles: got %0d required 9", nm, nbusy); end
        total++; if (d_at !== ed) begin bad++; $display("FAIL %s_diff: got %h required %h", nm, d_at, ed); end
        total++; if (b_at !== eb) begin bad++; $display("FAIL %s_borrow: got %b required %b", nm, b_at, eb); end
        total++; if (diff !== ed || borrow_out !== eb) begin
            bad++; $display("FAIL %s_hold: got %h/%b required %h/%b", nm, diff, borrow_out, ed, eb);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin_init = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", done); end
        total++; if (diff !== 8'h00) begin bad++; $display("FAIL reset_diff: got %h required 00", diff); end
        total++; if (borrow_out !== 1'b0) begin bad++; $display("FAIL reset_borrow: got %b required 0", borrow_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "basic");
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "underflow");
        run_op(8'hA7, 8'hA7, 1'b0, 8'h00, 1'b0, "equal");
    endtask

    // Starts during RUN and DONE must be dropped; result belongs to the first operands.
    task automatic test_start_ignored;
        int ndone;
        int lat;
        logic busy10;
        logic busy11;
        wait_idle("ignore");
        a = 8'h33; b = 8'h55; bin_init = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0; lat = 0; busy10 = 1'b1; busy11 = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin ndone++; lat = k; end
            if (k == 10) busy10 = busy;
            if (k == 11) busy11 = busy;
            if (k == 3)  begin start = 1'b1; a = 8'h01; b = 8'h01; end
            if (k == 4)  start = 1'b0;
            if (k == 9)  start = 1'b1;
            if (k == 10) start = 1'b0;
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d required 1", ndone); end
        total++; if (lat !== 9) begin bad++; $display("FAIL ignore_latency: got %0d required 9", lat); end
        total++; if (diff !== 8'hDE || borrow_out !== 1'b1) begin
            bad++; $display("FAIL ignore_result: got %h/%b required de/1", diff, borrow_out);
        end
        total++; if (busy10 !== 1'b0 || busy11 !== 1'b0) begin
            bad++; $display("FAIL ignore_no_queue: busy after done %b%b required 00", busy10, busy11);
        end
        run_op(8'h64, 8'h32, 1'b0, 8'h32, 1'b0, "after_ignore");
    endtask

    task automatic test_reset_mid_run;
        int ndone;
        wait_idle("rstmid");
        a = 8'h5A; b = 8'h3C; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rstmid_ctrl: busy/done %b/%b required 0/0", busy, done);
        end
        total++; if (diff !== 8'h00 || borrow_out !== 1'b0) begin
            bad++; $display("FAIL rstmid_result: got %h/%b required 00/0", diff, borrow_out);
        end
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d required 0", ndone); end
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "after_reset");
    endtask

    task automatic test_bin;
`ifdef SERIAL_SUB_BIN_EN
        run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "bin_exact");
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "bin_wrap");
`endif
    endtask

    // Start held high: second operation accepted on first IDLE cycle, dones 10 apart.
    task automatic test_back_to_back;
        int d1;
        int d2;
        int ndone;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        wait_idle("b2b");
        a = 8'h5A; b = 8'h3C; bin_init = 1'b0; start = 1'b1;
        d1 = 0; d2 = 0; ndone = 0; r1 = '0; r2 = '0;
        @(posedge clk);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (d1 == 0) begin d1 = k; r1 = diff; end
                else if (d2 == 0) begin d2 = k; r2 = diff; end
            end
            if (k == 1)  begin a = 8'hC8; b = 8'h64; end
            if (k == 12) start = 1'b0;
        end
        total++; if (ndone !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d required 2", ndone); end
        total++; if (d1 !== 9) begin bad++; $display("FAIL b2b_first_latency: got %0d required 9", d1); end
        total++; if (d2 - d1 !== 10) begin bad++; $display("FAIL b2b_spacing: got %0d required 10", d2 - d1); end
        total++; if (r1 !== 8'h1E) begin bad++; $display("FAIL b2b_first_diff: got %h required 1e", r1); end
        total++; if (r2 !== 8'h64) begin bad++; $display("FAIL b2b_second_diff: got %h required 64", r2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_ignored();
        test_reset_mid_run();
        test_bin();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller that sequences a single 1-bit `full_sub` cell over a WIDTH-bit operand pair. It processes one bit per clock, LSB first, and registers the borrow between cycles. On completion it returns a WIDTH-bit difference and a final borrow. It sits between a requesting datapath and the shared `full_sub` cell, replacing a WIDTH-wide ripple subtractor where area matters more than latency.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range is WIDTH >= 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `a` input WIDTH: minuend; captured on the accepted start edge.
- `b` input WIDTH: subtrahend; captured on the accepted start edge.
- `bin_init` input 1: initial borrow-in; present only when `SERIAL_SUB_BIN_EN` is defined.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle completion strobe.
- `diff` output WIDTH: result of a - b - bin_init (mod 2^WIDTH).
- `borrow_out` output 1: final borrow; 1 when a < b + bin_init.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1.
  - Load the operand shift registers from `a` and `b`.
  - Load the borrow register from `bin_init`, or 0 when the macro is absent.
  - Clear the bit counter to 0.
- RUN, each cycle:
  - Drive `full_sub` with the current LSBs of the operand registers and the borrow register.
  - Shift the cell's diff output into the result register MSB side, shifting right.
  - Latch the cell's barrow output into the borrow register.
  - Increment the counter.
- RUN -> DONE on the edge that processes bit WIDTH-1. The counter is $clog2(WIDTH) bits and compares against WIDTH-1, with no wrap.
- DONE -> IDLE unconditionally on the next edge.
- `start` in RUN or DONE is ignored and not queued. Operand changes after capture have no effect.
- `diff` and `borrow_out` are registered. They update only at the RUN->DONE edge and hold until the next completion, including through IDLE.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, operand/borrow registers=0.
- Reset asserted mid-operation aborts immediately: all of the above return to reset values and no done is produced.

## Timing
- Accepted start at rising edge E0.
- Bits 0..WIDTH-1 are processed at edges E1..EWIDTH.
- `diff`/`borrow_out` are valid and `done`=1 in the cycle after edge EWIDTH. Latency is WIDTH+1 cycles from start sample to done.
- `busy` rises after E0 and falls after E(WIDTH+1).
- Minimum start-to-start spacing is WIDTH+2 cycles. A start held high continuously is accepted in the first IDLE cycle.
- `done` is exactly one cycle wide and coincides with state DONE.

## Configuration
- `SERIAL_SUB_BIN_EN` defined: port `bin_init` exists and is captured at start. This enables multi-word chained subtraction, with the `borrow_out` of one word fed to `bin_init` of the next.
- `SERIAL_SUB_BIN_EN` undefined: no `bin_init` port; initial borrow is hard-wired 0. Behaviour is otherwise identical.

## Structure
- Shared package `serial_sub_pkg`:
  - State encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10. Encoding 2'b11 is illegal and recovers to IDLE.
  - Default width constant 8.
- One sub-module: the existing 1-bit `full_sub` cell (ports a, b, bin, diff, barrow), instantiated once.
- All sequencing, counter and shift registers live in `serial_sub_ctrl`.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start 1 cycle:
  - done exactly 9 cycles after the start sample.
  - diff=0x1E, borrow_out=0.
  - busy high 9 cycles.
- a=0x00, b=0x01: diff=0xFF, borrow_out=1. a=0xA7, b=0xA7: diff=0x00, borrow_out=0.
- Start pulse at cycle 3 of a running operation, with different operands:
  - Pulse ignored.
  - Single done with the original result.
  - Next start accepted only after return to IDLE.
- rst_n asserted at cycle 4 of RUN:
  - All outputs 0 immediately (asynchronously).
  - No done.
  - A fresh start after release yields the correct result.
- With `SERIAL_SUB_BIN_EN`:
  - a=0x10, b=0x0F, bin_init=1: diff=0x00, borrow_out=0.
  - a=0x00, b=0x00, bin_init=1: diff=0xFF, borrow_out=1.
- Back-to-back: start held high across two operations gives two dones spaced exactly 10 cycles apart, each with the correct result.
